// File: rtl/riscv_next_strategy_gshare_ras.sv
// riscv_next_strategy_gshare_ras
//   Next-PC predictor beside fetch: tagged direct-mapped BTB, gshare PHT
//   (pc XOR speculative global history) and a circular return address stack.
//   Speculative history / RAS pointer are restored from committed copies on
//   flush. Lookup is purely combinational from i_if_pc.
// Ports:
//   clk, nreset        clock (rising) / async active-low reset
//   enable, i_stall    state advances only when enable && !i_stall
//   i_if_pc            fetch PC to predict for
//   o_inject(_addr)    redirect request and target (addr is 0 when no inject)
//   i_pm_flush         restore speculative history/pointer from commit state
//   i_upd_*            resolved control-flow update (kind 11 = ignore)
module riscv_next_strategy_gshare_ras #(
  parameter int ADDR_WIDTH      = 64,
  parameter int BTB_INDEX_WIDTH = 4,
  parameter int BTB_TAG_WIDTH   = 8,
  parameter int GHR_WIDTH       = 6,
  parameter int PHT_INDEX_WIDTH = 8,
  parameter int COUNTER_WIDTH   = 2,
  parameter int RAS_DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  i_stall,
  input  logic [ADDR_WIDTH-1:0] i_if_pc,
  output logic                  o_inject,
  output logic [ADDR_WIDTH-1:0] o_inject_addr,
  input  logic                  i_pm_flush,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic [1:0]            i_upd_kind,
  input  logic                  i_upd_taken,
  input  logic                  i_upd_call,
  input  logic                  i_upd_ret
);
  localparam int BTB_N = 1 << BTB_INDEX_WIDTH;
  localparam int PHT_N = 1 << PHT_INDEX_WIDTH;
  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = SP_W + 1;
  localparam int TGT_W = ADDR_WIDTH - 2;
  localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = COUNTER_WIDTH'((1 << (COUNTER_WIDTH-1)) - 1);
  localparam logic [CNT_W-1:0]         CNT_MAX  = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {BT_BR, BT_JMP, BT_CALL, BT_RET} btb_type_e;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_WIDTH-1:0] tag;
    logic [TGT_W-1:0]         target;
    btb_type_e                kind;
  } btb_entry_t;

  btb_entry_t               btb_q [BTB_N];
  logic [COUNTER_WIDTH-1:0] pht_q [PHT_N];
  logic [TGT_W-1:0]         ras_q [RAS_DEPTH];

  logic [GHR_WIDTH-1:0] spec_ghr_q, spec_ghr_d, commit_ghr_q, commit_ghr_d;
  logic [SP_W-1:0]      spec_sp_q, spec_sp_d, commit_sp_q, commit_sp_d;
  logic [CNT_W-1:0]     spec_cnt_q, spec_cnt_d, commit_cnt_q, commit_cnt_d;

  logic active;
  assign active = enable && !i_stall;

  // ---------------- fetch-side lookup ----------------
  logic [BTB_INDEX_WIDTH-1:0] f_idx;
  logic [BTB_TAG_WIDTH-1:0]   f_tag;
  btb_entry_t                 f_ent;
  logic                       f_hit, f_taken, ras_push;
  logic [PHT_INDEX_WIDTH-1:0] f_pht_idx, spec_ghr_ext, commit_ghr_ext;
  logic [TGT_W-1:0]           f_link, ras_top;

  // History is narrower than the PHT index; zero-extend before the XOR.
  always_comb begin
    spec_ghr_ext                    = '0;
    spec_ghr_ext[GHR_WIDTH-1:0]     = spec_ghr_q;
    commit_ghr_ext                  = '0;
    commit_ghr_ext[GHR_WIDTH-1:0]   = commit_ghr_q;
  end

  assign f_idx     = i_if_pc[2 +: BTB_INDEX_WIDTH];
  assign f_tag     = i_if_pc[BTB_INDEX_WIDTH+2 +: BTB_TAG_WIDTH];
  assign f_ent     = btb_q[f_idx];
  assign f_hit     = f_ent.valid && (f_ent.tag == f_tag);
  assign f_pht_idx = i_if_pc[2 +: PHT_INDEX_WIDTH] ^ spec_ghr_ext;
  assign f_taken   = pht_q[f_pht_idx][COUNTER_WIDTH-1];
  assign f_link    = i_if_pc[ADDR_WIDTH-1:2] + TGT_W'(1);
  assign ras_top   = ras_q[spec_sp_q - SP_W'(1)];

  always_comb begin
    o_inject      = 1'b0;
    o_inject_addr = '0;
    if (f_hit) begin
      case (f_ent.kind)
        BT_BR: begin
          o_inject      = f_taken;
          o_inject_addr = f_taken ? {f_ent.target, 2'b00} : '0;
        end
        BT_JMP, BT_CALL: begin
          o_inject      = 1'b1;
          o_inject_addr = {f_ent.target, 2'b00};
        end
        BT_RET: begin
          o_inject      = 1'b1;
          // An empty stack falls back to whatever target the BTB last saw.
          o_inject_addr = (spec_cnt_q != '0) ? {ras_top, 2'b00} : {f_ent.target, 2'b00};
        end
      endcase
    end
  end

  // ---------------- resolve-side update ----------------
  logic [BTB_INDEX_WIDTH-1:0] u_idx;
  logic [BTB_TAG_WIDTH-1:0]   u_tag;
  logic [PHT_INDEX_WIDTH-1:0] u_pht_idx;
  logic [COUNTER_WIDTH-1:0]   u_ctr, u_ctr_d;
  logic                       u_hit, u_ok, u_br, u_call, u_ret, u_alloc;
  btb_type_e                  u_type;

  assign u_idx     = i_upd_pc[2 +: BTB_INDEX_WIDTH];
  assign u_tag     = i_upd_pc[BTB_INDEX_WIDTH+2 +: BTB_TAG_WIDTH];
  assign u_hit     = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);
  assign u_ok      = i_upd_valid && (i_upd_kind != 2'b11);
  assign u_br      = u_ok && (i_upd_kind == 2'b00);
  assign u_ret     = u_ok && i_upd_ret;
  assign u_call    = u_ok && i_upd_call && !i_upd_ret;
  // Never-taken branches that miss are not worth a BTB slot.
  assign u_alloc   = u_ok && !(u_br && !i_upd_taken && !u_hit);
  assign u_pht_idx = i_upd_pc[2 +: PHT_INDEX_WIDTH] ^ commit_ghr_ext;
  assign u_ctr     = pht_q[u_pht_idx];

  always_comb begin
    u_type = i_upd_ret ? BT_RET : i_upd_call ? BT_CALL :
             (i_upd_kind == 2'b00) ? BT_BR : BT_JMP;
    u_ctr_d = u_ctr;
    if (i_upd_taken && (u_ctr != '1))       u_ctr_d = u_ctr + COUNTER_WIDTH'(1);
    else if (!i_upd_taken && (u_ctr != '0)) u_ctr_d = u_ctr - COUNTER_WIDTH'(1);
  end

  // Committed next state; flush restores from this, so a same-cycle update
  // is already folded in.
  always_comb begin
    commit_ghr_d = commit_ghr_q;
    commit_sp_d  = commit_sp_q;
    commit_cnt_d = commit_cnt_q;
    if (u_br) commit_ghr_d = GHR_WIDTH'({commit_ghr_q, i_upd_taken});
    if (u_ret) begin
      if (commit_cnt_q != '0) begin
        commit_sp_d  = commit_sp_q - SP_W'(1);
        commit_cnt_d = commit_cnt_q - CNT_W'(1);
      end
    end else if (u_call) begin
      commit_sp_d  = commit_sp_q + SP_W'(1);
      commit_cnt_d = (commit_cnt_q == CNT_MAX) ? CNT_MAX : commit_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    spec_ghr_d = spec_ghr_q;
    spec_sp_d  = spec_sp_q;
    spec_cnt_d = spec_cnt_q;
    ras_push   = 1'b0;
    if (i_pm_flush) begin
      spec_ghr_d = commit_ghr_d;
      spec_sp_d  = commit_sp_d;
      spec_cnt_d = commit_cnt_d;
    end else if (f_hit) begin
      case (f_ent.kind)
        BT_BR:   spec_ghr_d = GHR_WIDTH'({spec_ghr_q, f_taken});
        BT_CALL: begin
          // Pointer wraps, silently overwriting the oldest return address.
          ras_push   = 1'b1;
          spec_sp_d  = spec_sp_q + SP_W'(1);
          spec_cnt_d = (spec_cnt_q == CNT_MAX) ? CNT_MAX : spec_cnt_q + CNT_W'(1);
        end
        BT_RET: begin
          if (spec_cnt_q != '0) begin
            spec_sp_d  = spec_sp_q - SP_W'(1);
            spec_cnt_d = spec_cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_INIT;
      spec_ghr_q   <= '0;
      commit_ghr_q <= '0;
      spec_sp_q    <= '0;
      commit_sp_q  <= '0;
      spec_cnt_q   <= '0;
      commit_cnt_q <= '0;
    end else if (active) begin
      if (u_alloc)
        btb_q[u_idx] <= '{valid: 1'b1, tag: u_tag,
                          target: i_upd_target[ADDR_WIDTH-1:2], kind: u_type};
      if (u_br) pht_q[u_pht_idx] <= u_ctr_d;
      spec_ghr_q   <= spec_ghr_d;
      commit_ghr_q <= commit_ghr_d;
      spec_sp_q    <= spec_sp_d;
      commit_sp_q  <= commit_sp_d;
      spec_cnt_q   <= spec_cnt_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // RAS data needs no reset: entries are only read once spec_cnt says they
  // were pushed, and a push needs a BTB hit, which reset rules out.
  always_ff @(posedge clk) begin
    if (active && ras_push) ras_q[spec_sp_q] <= f_link;
  end

  logic unused_bits;
  assign unused_bits = ^{i_if_pc[1:0], i_upd_pc, i_upd_target[1:0]};

endmodule

// File: tb/tb_riscv_next_strategy_gshare_ras.sv
module tb_riscv_next_strategy_gshare_ras;
  localparam logic [63:0] PARK = 64'h1000;
  localparam int TY_BR = 0, TY_JMP = 1, TY_CALL = 2, TY_RET = 3;

  logic        clk = 1'b0;
  logic        nreset, enable, i_stall, i_pm_flush;
  logic [63:0] i_if_pc, o_inject_addr, i_upd_pc, i_upd_target;
  logic        o_inject, i_upd_valid, i_upd_taken, i_upd_call, i_upd_ret;
  logic [1:0]  i_upd_kind;

  int n_checks = 0;
  int n_err    = 0;

  riscv_next_strategy_gshare_ras dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall),
    .i_if_pc(i_if_pc), .o_inject(o_inject), .o_inject_addr(o_inject_addr),
    .i_pm_flush(i_pm_flush), .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc),
    .i_upd_target(i_upd_target), .i_upd_kind(i_upd_kind), .i_upd_taken(i_upd_taken),
    .i_upd_call(i_upd_call), .i_upd_ret(i_upd_ret)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit              mv   [16];
  int              mtag [16];
  longint unsigned mtgt [16];
  int              mtyp [16];
  int              mpht [256];
  longint unsigned mras [4];
  int sghr, cghr, ssp, csp, scnt, ccnt;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 0;
    for (int i = 0; i < 256; i++) mpht[i] = 1;
    sghr = 0; cghr = 0; ssp = 0; csp = 0; scnt = 0; ccnt = 0;
  endtask

  task automatic model_step();
    longint unsigned fpc = i_if_pc, upc = i_upd_pc;
    int  fi   = int'((fpc >> 2) % 16);
    int  ft   = int'((fpc >> 6) % 256);
    int  fp   = int'((fpc >> 2) % 256) ^ sghr;
    bit  fhit = mv[fi] && (mtag[fi] == ft);
    int  fty  = mtyp[fi];
    bit  ftk  = mpht[fp] >= 2;
    int  ui   = int'((upc >> 2) % 16);
    int  ut   = int'((upc >> 6) % 256);
    int  up   = int'((upc >> 2) % 256) ^ cghr;
    bit  uhit = mv[ui] && (mtag[ui] == ut);
    bit  uok  = i_upd_valid && (i_upd_kind != 2'b11);
    bit  ubr  = uok && (i_upd_kind == 2'b00);
    bit  uret = uok && i_upd_ret;
    bit  ucal = uok && i_upd_call && !i_upd_ret;
    int  ncg = cghr, ncs = csp, ncc = ccnt;
    if (ubr) ncg = ((cghr * 2) + int'(i_upd_taken)) % 64;
    if (uret) begin
      if (ccnt > 0) begin ncs = (csp + 3) % 4; ncc = ccnt - 1; end
    end else if (ucal) begin
      ncs = (csp + 1) % 4; ncc = (ccnt < 4) ? ccnt + 1 : 4;
    end
    if (uok && !(ubr && !i_upd_taken && !uhit)) begin
      mv[ui] = 1; mtag[ui] = ut; mtgt[ui] = i_upd_target & ~64'h3;
      mtyp[ui] = i_upd_ret ? TY_RET : i_upd_call ? TY_CALL :
                 (i_upd_kind == 2'b00) ? TY_BR : TY_JMP;
    end
    if (ubr) begin
      if (i_upd_taken) mpht[up] = (mpht[up] < 3) ? mpht[up] + 1 : 3;
      else             mpht[up] = (mpht[up] > 0) ? mpht[up] - 1 : 0;
    end
    cghr = ncg; csp = ncs; ccnt = ncc;
    if (i_pm_flush) begin
      sghr = ncg; ssp = ncs; scnt = ncc;
    end else if (fhit) begin
      if (fty == TY_BR) sghr = ((sghr * 2) + int'(ftk)) % 64;
      else if (fty == TY_CALL) begin
        mras[ssp] = fpc + 4; ssp = (ssp + 1) % 4; scnt = (scnt < 4) ? scnt + 1 : 4;
      end else if (fty == TY_RET && scnt > 0) begin
        ssp = (ssp + 3) % 4; scnt = scnt - 1;
      end
    end
  endtask

  task automatic model_out(output bit inj, output longint unsigned addr);
    longint unsigned fpc = i_if_pc;
    int fi = int'((fpc >> 2) % 16);
    int ft = int'((fpc >> 6) % 256);
    int fp = int'((fpc >> 2) % 256) ^ sghr;
    inj = 0; addr = 0;
    if (mv[fi] && mtag[fi] == ft) begin
      if (mtyp[fi] == TY_BR) begin
        if (mpht[fp] >= 2) begin inj = 1; addr = mtgt[fi]; end
      end else if (mtyp[fi] == TY_RET) begin
        inj = 1; addr = (scnt > 0) ? mras[(ssp + 3) % 4] : mtgt[fi];
      end else begin
        inj = 1; addr = mtgt[fi];
      end
    end
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) if (nreset && enable && !i_stall) model_step();
  always @(negedge nreset) model_reset();

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit              ei;
    longint unsigned ea;
    model_out(ei, ea);
    check("cyc_inject", o_inject, ei);
    check("cyc_addr", o_inject_addr, ea);
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic [1:0] kind,
                     input logic tk, input logic cl, input logic rt);
    i_upd_valid = 1; i_upd_pc = pc; i_upd_target = tgt; i_upd_kind = kind;
    i_upd_taken = tk; i_upd_call = cl; i_upd_ret = rt;
    tick();
    i_upd_valid = 0; i_upd_taken = 0; i_upd_call = 0; i_upd_ret = 0;
  endtask

  task automatic fetch(input logic [63:0] pc, input logic einj, input logic [63:0] eaddr,
                       input string name);
    i_if_pc = pc;
    @(negedge clk);
    check({name, "_inj"}, o_inject, einj);
    check({name, "_addr"}, o_inject_addr, eaddr);
    tick();
    i_if_pc = PARK;
  endtask

  task automatic do_reset();
    nreset = 0; tick(); tick(); nreset = 1;
  endtask

  task automatic flush_cycle();
    i_pm_flush = 1; tick(); i_pm_flush = 0;
  endtask

  logic [63:0] call_pc  [5] = '{64'h400, 64'h408, 64'h40C, 64'h414, 64'h418};
  logic [63:0] ret_addr [5] = '{64'h41C, 64'h418, 64'h410, 64'h40C, 64'hAB0};

  initial begin
    model_reset();
    nreset = 0; enable = 1; i_stall = 0; i_pm_flush = 0; i_if_pc = PARK;
    i_upd_valid = 0; i_upd_pc = 0; i_upd_target = 0; i_upd_kind = 0;
    i_upd_taken = 0; i_upd_call = 0; i_upd_ret = 0;
    tick(); tick();

    // 1: reset state
    i_if_pc = 64'h100;
    @(negedge clk);
    check("t1_rst_inj", o_inject, 0);
    check("t1_rst_addr", o_inject_addr, 0);
    tick();
    nreset = 1;
    fetch(64'h100, 0, 64'h0, "t1_post");

    // 2: taken branch learns in two updates
    upd(64'h200, 64'h80, 2'b00, 1, 0, 0);
    upd(64'h200, 64'h80, 2'b00, 1, 0, 0);
    fetch(64'h200, 1, 64'h80, "t2_taken");

    // 3: alternating branch trained, then history resynced by a flush
    for (int i = 0; i < 40; i++) upd(64'h300, 64'h40, 2'b00, (i % 2) == 0, 0, 0);
    flush_cycle();
    for (int i = 0; i < 7; i++) begin
      i_if_pc = 64'h300;
      @(negedge clk);
      check("t3_alt_inj", o_inject, (i % 2) == 0);
      check("t3_alt_addr", o_inject_addr, ((i % 2) == 0) ? 64'h40 : 64'h0);
      if (i < 6) tick();
    end
    // reset mid-cycle while a taken prediction is showing
    #1 nreset = 0;
    #1;
    check("t1_async_rst_inj", o_inject, 0);
    check("t1_async_rst_addr", o_inject_addr, 0);
    tick(); tick();
    i_if_pc = PARK; nreset = 1;

    // 4: call/return and RAS overflow
    upd(64'h400, 64'h800, 2'b01, 0, 1, 0);
    upd(64'h810, 64'hAB0, 2'b10, 0, 0, 1);
    fetch(64'h400, 1, 64'h800, "t4_call");
    fetch(64'h810, 1, 64'h404, "t4_ret");
    for (int i = 1; i < 5; i++) upd(call_pc[i], 64'h800, 2'b01, 0, 1, 0);
    for (int i = 0; i < 5; i++) fetch(call_pc[i], 1, 64'h800, "t4_nest_call");
    for (int i = 0; i < 5; i++) fetch(64'h810, 1, ret_addr[i], "t4_nest_ret");

    // 5: flush restores speculative history
    do_reset();
    for (int i = 0; i < 3; i++) upd(64'h200, 64'h80, 2'b00, 1, 0, 0);
    for (int i = 0; i < 5; i++) upd(64'h1004, 64'h900, 2'b00, 0, 0, 0);
    upd(64'h1004, 64'h900, 2'b00, 1, 0, 0);
    for (int i = 0; i < 3; i++) fetch(64'h200, 1, 64'h80, "t5_spec");
    check("t5_model_sghr_spec", sghr, 7);
    check("t5_model_cghr", cghr, 1);
    flush_cycle();
    check("t5_model_sghr_flush", sghr, 1);
    fetch(64'h200, 1, 64'h80, "t5_restored");
    i_pm_flush = 1;
    upd(64'h1004, 64'h900, 2'b00, 1, 0, 0);
    i_pm_flush = 0;
    check("t5_model_sghr_flush_upd", sghr, 3);
    fetch(64'h200, 1, 64'h80, "t5_after_upd");

    // 6: stall freezes everything, release applies update and push together
    upd(64'h400, 64'h800, 2'b01, 0, 1, 0);
    upd(64'h810, 64'hAB0, 2'b10, 0, 0, 1);
    i_stall = 1; i_if_pc = 64'h400;
    i_upd_valid = 1; i_upd_pc = 64'h308; i_upd_target = 64'h40; i_upd_kind = 2'b00;
    i_upd_taken = 1; i_upd_call = 0; i_upd_ret = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_stall_inj", o_inject, 1);
      check("t6_stall_addr", o_inject_addr, 64'h800);
      tick();
    end
    i_stall = 0;
    tick();
    i_upd_valid = 0; i_upd_taken = 0;
    fetch(64'h810, 1, 64'h404, "t6_ret_once");
    fetch(64'h810, 1, 64'hAB0, "t6_ret_empty");
    fetch(64'h308, 1'b0, 64'h0, "t6_br_new");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
